// File: rtl/counter_seq_ctrl.sv
// Command sequencer for one up/down counter: load start value, step to end, pulse done.
// Optional prescaler between steps is compiled in with `define CNT_SEQ_PRESCALE_EN.
module counter_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4,
    parameter int PS_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             cnt_ce,
    output logic             cnt_ld,
    output logic             cnt_cu,
    output logic             cnt_cd,
    output logic [WIDTH-1:0] cnt_data,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic             dir_q;
    logic             accept;
    logic             tick;

    assign cmd_ready = (state_q == IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state_q != IDLE);
    assign cnt_data  = start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                start_q <= cmd_start;
                end_q   <= cmd_end;
                dir_q   <= cmd_dir;
            end
        end
    end

`ifdef CNT_SEQ_PRESCALE_EN
    localparam logic [PS_WIDTH-1:0] PsLast = PS_WIDTH'(PRESCALE - 1);

    logic [PS_WIDTH-1:0] ps_q, ps_d;

    // Held at zero outside RUN so every run starts a fresh prescale period
    always_comb begin
        ps_d = ps_q;
        if (state_q != RUN) begin
            ps_d = '0;
        end else if (ps_q == PsLast) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign tick = (ps_q == PsLast);
`else
    // Every RUN cycle is a step slot; true for any legal parameter set
    assign tick = (PRESCALE > 0) && (PS_WIDTH > 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_ce  = 1'b0;
        cnt_ld  = 1'b0;
        cnt_cu  = 1'b0;
        cnt_cd  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_ce  = 1'b1;
                    cnt_ld  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == end_q) begin
                    state_d = DONE;
                end else if (tick) begin
                    cnt_ce = 1'b1;
                    cnt_cu = dir_q;
                    cnt_cd = ~dir_q;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl driving a behavioural up/down counter.
// Expectations follow the cycle formulas with P=4 when CNT_SEQ_PRESCALE_EN is set.
module tb_counter_seq_ctrl;

`ifdef CNT_SEQ_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif
    localparam int L = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_start = '0;
    logic [3:0] cmd_end = '0;
    logic       cmd_dir = 1'b0;
    logic       abort = 1'b0;
    logic       cnt_ce, cnt_ld, cnt_cu, cnt_cd;
    logic [3:0] cnt_data;
    logic [3:0] cq = '0;
    logic       busy, done;

    int n_chk = 0;
    int n_fail = 0;

    bit tr_ce [1:L];
    bit tr_ld [1:L];
    bit tr_cu [1:L];
    bit tr_cd [1:L];
    bit tr_dn [1:L];
    bit tr_bsy[1:L];
    bit tr_rdy[1:L];
    bit tr_acc[1:L];

    int ld_cyc, n_step, first_step, last_step;
    int done_cyc, n_done, n_acc, n_cu, n_cd;

    counter_seq_ctrl #(
        .WIDTH   (4),
        .PRESCALE(4),
        .PS_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_start(cmd_start),
        .cmd_end  (cmd_end),
        .cmd_dir  (cmd_dir),
        .abort    (abort),
        .cnt_ce   (cnt_ce),
        .cnt_ld   (cnt_ld),
        .cnt_cu   (cnt_cu),
        .cnt_cd   (cnt_cd),
        .cnt_data (cnt_data),
        .cnt_q    (cq),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Counter under control; deliberately not reset by rst_n
    always_ff @(posedge clk) begin
        if (cnt_ce) begin
            if (cnt_ld) cq <= cnt_data;
            else if (cnt_cu) cq <= cq + 4'd1;
            else if (cnt_cd) cq <= cq - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1; cycle A is the current one, returns in A+1
    task automatic issue(input logic [3:0] s, input logic [3:0] e,
                         input logic d, input bit hold);
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_end   = e;
        cmd_dir   = d;
        @(negedge clk);
        check("accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = hold;
        cmd_start = ~s;
        cmd_end   = ~e;
        cmd_dir   = ~d;
    endtask

    task automatic trace(input int abort_at);
        ld_cyc = 0; n_step = 0; first_step = 0; last_step = 0;
        done_cyc = 0; n_done = 0; n_cu = 0; n_cd = 0;
        for (int i = 1; i <= L; i++) begin
            abort = (i == abort_at);
            @(negedge clk);
            tr_ce[i]  = cnt_ce;
            tr_ld[i]  = cnt_ld;
            tr_cu[i]  = cnt_cu;
            tr_cd[i]  = cnt_cd;
            tr_dn[i]  = done;
            tr_bsy[i] = busy;
            tr_rdy[i] = cmd_ready;
            tr_acc[i] = cmd_valid & cmd_ready;
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        for (int i = 1; i <= L; i++) begin
            if (tr_ld[i] && ld_cyc == 0) ld_cyc = i;
            if (tr_dn[i]) begin
                n_done++;
                if (done_cyc == 0) done_cyc = i;
            end
            if (tr_cu[i]) n_cu++;
            if (tr_cd[i]) n_cd++;
            if (tr_ce[i] && !tr_ld[i] && (done_cyc == 0)) begin
                n_step++;
                if (first_step == 0) first_step = i;
                last_step = i;
            end
        end
        n_acc = 0;
        for (int i = 1; i <= done_cyc; i++) begin
            if (tr_acc[i]) n_acc++;
        end
    endtask

    initial begin
        abort = 1'b1;
        #2;
        check("rst_rdy_abort", cmd_ready, 0);
        abort = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ce", {cnt_ce, cnt_ld, cnt_cu, cnt_cd}, 0);
        check("rst_data", cnt_data, 0);
        check("rst_rdy", cmd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 -> 6 up
        issue(4'd3, 4'd6, 1'b1, 1'b0);
        trace(0);
        check("up_ld", ld_cyc, 1);
        check("up_steps", n_step, 3);
        check("up_first", first_step, 1 + P);
        check("up_last", last_step, 1 + 3 * P);
        check("up_done", done_cyc, 3 + 3 * P);
        check("up_ndone", n_done, 1);
        check("up_ncd", n_cd, 0);
        check("up_q", cq, 6);
        check("up_busy1", tr_bsy[1], 1);
        check("up_busyd", tr_bsy[3 + 3 * P], 1);
        check("up_idle", tr_bsy[4 + 3 * P], 0);
        check("up_rdy", tr_rdy[4 + 3 * P], 1);

        // 2 -> 14 down through wrap
        issue(4'd2, 4'd14, 1'b0, 1'b0);
        trace(0);
        check("dn_steps", n_step, 4);
        check("dn_ncu", n_cu, 0);
        check("dn_last", last_step, 1 + 4 * P);
        check("dn_done", done_cyc, 3 + 4 * P);
        check("dn_q", cq, 14);

        // start == end
        issue(4'd5, 4'd5, 1'b1, 1'b0);
        trace(0);
        check("eq_ld", ld_cyc, 1);
        check("eq_steps", n_step, 0);
        check("eq_done", done_cyc, 3);
        check("eq_q", cq, 5);

        // abort in RUN at A+4
        issue(4'd0, 4'd9, 1'b1, 1'b0);
        trace(4);
        check("ab_ce", tr_ce[4], 0);
        check("ab_ndone", n_done, 0);
        check("ab_steps", n_step, (P == 1) ? 2 : 0);
        check("ab_q", cq, (P == 1) ? 2 : 0);
        check("ab_rdy", tr_rdy[5], 1);
        check("ab_busy", tr_bsy[5], 0);

        // 0 -> 2 up, step spacing
        issue(4'd0, 4'd2, 1'b1, 1'b0);
        trace(0);
        check("ps_steps", n_step, 2);
        check("ps_first", first_step, 1 + P);
        check("ps_last", last_step, 1 + 2 * P);
        check("ps_done", done_cyc, 3 + 2 * P);

        // cmd_valid held: one accept per run, next taken right after DONE
        issue(4'd1, 4'd3, 1'b1, 1'b1);
        cmd_start = 4'd1;
        cmd_end   = 4'd3;
        cmd_dir   = 1'b1;
        trace(0);
        cmd_valid = 1'b0;
        check("hold_done", done_cyc, 3 + 2 * P);
        check("hold_nacc", n_acc, 0);
        check("hold_b2b", tr_acc[done_cyc + 1], 1);
        for (int i = 0; i < 60 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("hold_idle", busy, 0);

        // asynchronous reset mid-RUN
        issue(4'd0, 4'd9, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cnt", {cnt_ce, cnt_ld, cnt_cu, cnt_cd}, 0);
        check("arst_data", cnt_data, 0);
        check("arst_done", done, 0);
        check("arst_rdy", cmd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'd4, 4'd7, 1'b1, 1'b0);
        trace(0);
        check("post_steps", n_step, 3);
        check("post_done", done_cyc, 3 + 3 * P);
        check("post_q", cq, 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
